// File: rtl/lockstep_comparator_pkg.sv
// rtl/lockstep_comparator_pkg.sv - shared lockstep state encodings and defaults
// Optional syndrome capture is selected with the LOCKSTEP_SYNDROME_EN macro.
package lockstep_comparator_pkg;

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } lc_state_e;

  // Matches the depth of the upstream lockstep delay stage.
  localparam int DEFAULT_ARM_CYCLES = 2;

endpackage

// File: rtl/lockstep_comparator_if.sv
// rtl/lockstep_comparator_if.sv - compare/fault signal bundle between core pair and comparator
interface lockstep_comparator_if #(
  parameter int OPERAND_WIDTH = 32,
  parameter int CNT_WIDTH     = 8
);

  logic                     enable_i;
  logic [OPERAND_WIDTH-1:0] master_delayed_i;
  logic [OPERAND_WIDTH-1:0] checker_i;
  logic                     clear_i;
  logic                     mismatch_o;
  logic                     error_o;
  logic [CNT_WIDTH-1:0]     err_count_o;
  logic                     armed_o;
  logic [OPERAND_WIDTH-1:0] syndrome_o;

  modport master (
    output enable_i, master_delayed_i, checker_i, clear_i,
    input  mismatch_o, error_o, err_count_o, armed_o, syndrome_o
  );

  modport slave (
    input  enable_i, master_delayed_i, checker_i, clear_i,
    output mismatch_o, error_o, err_count_o, armed_o, syndrome_o
  );

endinterface

// File: rtl/lockstep_sat_counter.sv
// rtl/lockstep_sat_counter.sv - saturating up-counter with synchronous clear
module lockstep_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX_COUNT)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/lockstep_comparator.sv
// rtl/lockstep_comparator.sv - lockstep output comparator with arming, mismatch count and sticky fault
// Define LOCKSTEP_SYNDROME_EN to build the first-mismatch syndrome capture register.
module lockstep_comparator
  import lockstep_comparator_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter int ARM_CYCLES    = DEFAULT_ARM_CYCLES,
  parameter int CNT_WIDTH     = 8,
  parameter int ERR_THRESHOLD = 1
) (
  input logic                  clk,
  input logic                  rst,
  lockstep_comparator_if.slave lc_if
);

  localparam int ARM_W = $clog2(ARM_CYCLES + 1);

  if (ERR_THRESHOLD < 1 || ERR_THRESHOLD > (2 ** CNT_WIDTH) - 1) begin : g_bad_threshold
    $error("lockstep_comparator: ERR_THRESHOLD outside 1..2^CNT_WIDTH-1");
  end
  if (ARM_CYCLES < 1) begin : g_bad_arm
    $error("lockstep_comparator: ARM_CYCLES must be at least 1");
  end

  lc_state_e                state_q, state_d;
  logic                     mismatch_q, mismatch_d;
  logic                     error_q, error_d;
  logic                     arm_clr, arm_inc;
  logic                     err_clr, err_inc;
  logic [ARM_W-1:0]         arm_count;
  logic [CNT_WIDTH-1:0]     err_count;
  logic [CNT_WIDTH:0]       err_next;
  logic [OPERAND_WIDTH-1:0] diff;

  assign diff     = lc_if.master_delayed_i ^ lc_if.checker_i;
  assign err_next = {1'b0, err_count} + (CNT_WIDTH + 1)'(1);

  lockstep_sat_counter #(.WIDTH(ARM_W)) u_arm_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (arm_clr),
    .inc_i   (arm_inc),
    .count_o (arm_count)
  );

  lockstep_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (err_clr),
    .inc_i   (err_inc),
    .count_o (err_count)
  );

  always_comb begin
    state_d    = state_q;
    mismatch_d = 1'b0;
    error_d    = error_q;
    arm_clr    = 1'b0;
    arm_inc    = 1'b0;
    err_clr    = 1'b0;
    err_inc    = 1'b0;
    if (lc_if.clear_i) begin
      state_d = ST_ARM;
      error_d = 1'b0;
      arm_clr = 1'b1;
      err_clr = 1'b1;
    end else begin
      case (state_q)
        ST_ARM: begin
          if (!lc_if.enable_i) begin
            arm_clr = 1'b1;
          end else if (arm_count == ARM_W'(ARM_CYCLES - 1)) begin
            // Counter parks at zero for the whole MONITOR stay.
            state_d = ST_MONITOR;
            arm_clr = 1'b1;
          end else begin
            arm_inc = 1'b1;
          end
        end
        ST_MONITOR: begin
          if (!lc_if.enable_i) begin
            state_d = ST_ARM;
            arm_clr = 1'b1;
          end else if (|diff) begin
            mismatch_d = 1'b1;
            err_inc    = 1'b1;
            if (err_next >= (CNT_WIDTH + 1)'(ERR_THRESHOLD)) begin
              state_d = ST_FAULT;
              error_d = 1'b1;
            end
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_ARM;
          arm_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ARM;
      mismatch_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mismatch_q <= mismatch_d;
      error_q    <= error_d;
    end
  end

`ifdef LOCKSTEP_SYNDROME_EN
  logic [OPERAND_WIDTH-1:0] syndrome_q;

  // Only the first counted mismatch since reset/clear is kept for diagnosis.
  always_ff @(posedge clk) begin
    if (rst) begin
      syndrome_q <= '0;
    end else if (lc_if.clear_i) begin
      syndrome_q <= '0;
    end else if (err_inc && (err_count == '0)) begin
      syndrome_q <= diff;
    end
  end

  assign lc_if.syndrome_o = syndrome_q;
`else
  assign lc_if.syndrome_o = '0;
`endif

  assign lc_if.mismatch_o  = mismatch_q;
  assign lc_if.error_o     = error_q;
  assign lc_if.err_count_o = err_count;
  assign lc_if.armed_o     = (state_q == ST_MONITOR);

endmodule

// File: tb/tb_lockstep_comparator.sv
// tb/tb_lockstep_comparator.sv - directed and random checks of lockstep_comparator against a reference model
module tb_lockstep_comparator;

  localparam int ARM = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic [31:0] md;
  logic [31:0] ck;

  int ntot  = 0;
  int npass = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  lockstep_comparator_if #(.OPERAND_WIDTH(32), .CNT_WIDTH(8)) if0 ();
  lockstep_comparator_if #(.OPERAND_WIDTH(32), .CNT_WIDTH(8)) if1 ();
  lockstep_comparator_if #(.OPERAND_WIDTH(32), .CNT_WIDTH(2)) if2 ();

  assign if0.enable_i = en;  assign if0.master_delayed_i = md;  assign if0.checker_i = ck;  assign if0.clear_i = clr;
  assign if1.enable_i = en;  assign if1.master_delayed_i = md;  assign if1.checker_i = ck;  assign if1.clear_i = clr;
  assign if2.enable_i = en;  assign if2.master_delayed_i = md;  assign if2.checker_i = ck;  assign if2.clear_i = clr;

  lockstep_comparator #(.OPERAND_WIDTH(32), .ARM_CYCLES(ARM), .CNT_WIDTH(8), .ERR_THRESHOLD(1))
    dut0 (.clk(clk), .rst(rst), .lc_if(if0.slave));
  lockstep_comparator #(.OPERAND_WIDTH(32), .ARM_CYCLES(ARM), .CNT_WIDTH(8), .ERR_THRESHOLD(3))
    dut1 (.clk(clk), .rst(rst), .lc_if(if1.slave));
  lockstep_comparator #(.OPERAND_WIDTH(32), .ARM_CYCLES(ARM), .CNT_WIDTH(2), .ERR_THRESHOLD(3))
    dut2 (.clk(clk), .rst(rst), .lc_if(if2.slave));

  logic        mis_w[3];
  logic        err_w[3];
  logic        arm_w[3];
  logic [7:0]  cnt_w[3];
  logic [31:0] syn_w[3];

  assign mis_w[0] = if0.mismatch_o; assign err_w[0] = if0.error_o; assign arm_w[0] = if0.armed_o;
  assign cnt_w[0] = if0.err_count_o; assign syn_w[0] = if0.syndrome_o;
  assign mis_w[1] = if1.mismatch_o; assign err_w[1] = if1.error_o; assign arm_w[1] = if1.armed_o;
  assign cnt_w[1] = if1.err_count_o; assign syn_w[1] = if1.syndrome_o;
  assign mis_w[2] = if2.mismatch_o; assign err_w[2] = if2.error_o; assign arm_w[2] = if2.armed_o;
  assign cnt_w[2] = {6'd0, if2.err_count_o}; assign syn_w[2] = if2.syndrome_o;

  // Reference model: one entry per DUT, kept as plain counters and flags.
  int          thr[3]  = '{1, 3, 3};
  int          cmax[3] = '{255, 255, 3};
  int          fill[3];
  int          cnt[3];
  bit          mon[3];
  bit          fault[3];
  bit          mis[3];
  logic [31:0] syn[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit e, input logic [31:0] a, input logic [31:0] b, input bit c);
    for (int i = 0; i < 3; i++) begin
      mis[i] = 1'b0;
      if (r || c) begin
        fill[i] = 0; cnt[i] = 0; mon[i] = 1'b0; fault[i] = 1'b0; syn[i] = '0;
      end else if (fault[i]) begin
        // sticky until clear or reset
      end else if (!mon[i]) begin
        if (e) begin
          fill[i]++;
          if (fill[i] >= ARM) begin mon[i] = 1'b1; fill[i] = 0; end
        end else begin
          fill[i] = 0;
        end
      end else if (!e) begin
        mon[i] = 1'b0;
        fill[i] = 0;
      end else if (a != b) begin
        mis[i] = 1'b1;
        if (cnt[i] == 0) syn[i] = a ^ b;
        if (cnt[i] < cmax[i]) cnt[i]++;
        if (cnt[i] >= thr[i]) begin fault[i] = 1'b1; mon[i] = 1'b0; end
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_syn;
    for (int i = 0; i < 3; i++) begin
`ifdef LOCKSTEP_SYNDROME_EN
      exp_syn = syn[i];
`else
      exp_syn = '0;
`endif
      chk($sformatf("d%0d_mismatch", i), {31'd0, mis_w[i]}, {31'd0, mis[i]});
      chk($sformatf("d%0d_error", i),    {31'd0, err_w[i]}, {31'd0, fault[i]});
      chk($sformatf("d%0d_armed", i),    {31'd0, arm_w[i]}, {31'd0, mon[i]});
      chk($sformatf("d%0d_count", i),    {24'd0, cnt_w[i]}, 32'(cnt[i]));
      chk($sformatf("d%0d_syndrome", i), syn_w[i], exp_syn);
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [31:0] a, input logic [31:0] b, input bit c);
    rst = r; en = e; md = a; ck = b; clr = c;
    @(posedge clk);
    model_update(r, e, a, b, c);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1; en = 1'b0; md = '0; ck = '0; clr = 1'b0;

    // Reset values against constants
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_d%0d_armed", i), {31'd0, arm_w[i]}, 32'd0);
      chk($sformatf("rst_d%0d_count", i), {24'd0, cnt_w[i]}, 32'd0);
      chk($sformatf("rst_d%0d_error", i), {31'd0, err_w[i]}, 32'd0);
    end

    // Arming: inputs differ all along, only the post-arm cycle counts
    step(1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
    chk("arm_c1_mismatch", {31'd0, mis_w[0]}, 32'd0);
    chk("arm_c1_armed",    {31'd0, arm_w[0]}, 32'd0);
    step(1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
    chk("arm_c2_mismatch", {31'd0, mis_w[0]}, 32'd0);
    chk("arm_c3_armed",    {31'd0, arm_w[0]}, 32'd1);
    step(1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
    chk("arm_c4_mismatch", {31'd0, mis_w[0]}, 32'd1);
    chk("arm_c4_error_t1", {31'd0, err_w[0]}, 32'd1);
    chk("arm_c4_count_t3", {24'd0, cnt_w[1]}, 32'd1);

    // Clear everything and re-arm with equal data
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);

    // Clean run
    for (int k = 0; k < 1000; k++) begin
      w = $urandom;
      step(1'b0, 1'b1, w, w, 1'b0);
    end
    chk("clean_count", {24'd0, cnt_w[1]}, 32'd0);
    chk("clean_error", {31'd0, err_w[0]}, 32'd0);

    // Threshold: mismatches on MONITOR cycles 10, 20, 30, 40
    for (int k = 1; k <= 40; k++) begin
      w = $urandom;
      if (k == 10)      step(1'b0, 1'b1, 32'h00000010, 32'h0, 1'b0);
      else if (k == 20) step(1'b0, 1'b1, 32'h000000FF, 32'h0, 1'b0);
      else if (k == 30) step(1'b0, 1'b1, w, w ^ 32'h1, 1'b0);
      else if (k == 40) step(1'b0, 1'b1, w, ~w, 1'b0);
      else              step(1'b0, 1'b1, w, w, 1'b0);
      if (k == 10) chk("thr_cnt1", {24'd0, cnt_w[1]}, 32'd1);
      if (k == 20) begin
        chk("thr_cnt2", {24'd0, cnt_w[1]}, 32'd2);
`ifdef LOCKSTEP_SYNDROME_EN
        chk("syn_held", syn_w[2], 32'h00000010);
`endif
      end
      if (k == 30) begin
        chk("thr_cnt3",  {24'd0, cnt_w[1]}, 32'd3);
        chk("thr_error", {31'd0, err_w[1]}, 32'd1);
      end
      if (k == 40) begin
        chk("fault_no_mismatch", {31'd0, mis_w[1]}, 32'd0);
        chk("fault_cnt_held",    {24'd0, cnt_w[1]}, 32'd3);
        chk("sat_cnt_w2",        {24'd0, cnt_w[2]}, 32'd3);
      end
    end

    // Clear priority over a same-cycle mismatch
    step(1'b0, 1'b1, 32'h5, 32'h6, 1'b1);
    chk("clr_armed",    {31'd0, arm_w[1]}, 32'd0);
    chk("clr_error",    {31'd0, err_w[1]}, 32'd0);
    chk("clr_count",    {24'd0, cnt_w[1]}, 32'd0);
    chk("clr_mismatch", {31'd0, mis_w[1]}, 32'd0);
    step(1'b0, 1'b1, 32'h7, 32'h7, 1'b0);
    step(1'b0, 1'b1, 32'h7, 32'h7, 1'b0);
    chk("clr_rearmed", {31'd0, arm_w[1]}, 32'd1);

    // Enable drop with a mismatch present
    step(1'b0, 1'b1, 32'h1, 32'h2, 1'b0);
    step(1'b0, 1'b0, 32'h1, 32'h2, 1'b0);
    chk("drop_mismatch", {31'd0, mis_w[1]}, 32'd0);
    chk("drop_armed",    {31'd0, arm_w[1]}, 32'd0);
    chk("drop_count",    {24'd0, cnt_w[1]}, 32'd1);
    step(1'b0, 1'b1, 32'h3, 32'h3, 1'b0);
    step(1'b0, 1'b1, 32'h3, 32'h3, 1'b0);
    chk("drop_rearmed", {31'd0, arm_w[1]}, 32'd1);
    chk("drop_count2",  {24'd0, cnt_w[1]}, 32'd1);

    // Random mix of enables, mismatches, clears and resets
    for (int k = 0; k < 600; k++) begin
      w = $urandom;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), w,
           ($urandom_range(0, 9) == 0) ? (w ^ (32'h1 << $urandom_range(0, 31))) : w,
           ($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
